// File: rtl/jtframe_inputs_pkg.sv
// Shared scancodes, joystick-word bit positions and the per-player control type
// used by the jtframe input mapper.
package jtframe_inputs_pkg;

  localparam logic [7:0] KEY_UP        = 8'h75;
  localparam logic [7:0] KEY_DOWN      = 8'h72;
  localparam logic [7:0] KEY_LEFT      = 8'h6B;
  localparam logic [7:0] KEY_RIGHT     = 8'h74;
  localparam logic [7:0] KEY_B0        = 8'h14;
  localparam logic [7:0] KEY_B0_ALT    = 8'h11;
  localparam logic [7:0] KEY_B1        = 8'h29;
  localparam logic [7:0] KEY_B2        = 8'h12;
  localparam logic [7:0] KEY_B3        = 8'h1A;
  localparam logic [7:0] KEY_P2_UP     = 8'h2D;
  localparam logic [7:0] KEY_P2_DOWN   = 8'h2B;
  localparam logic [7:0] KEY_P2_LEFT   = 8'h23;
  localparam logic [7:0] KEY_P2_RIGHT  = 8'h34;
  localparam logic [7:0] KEY_P2_B0     = 8'h1C;
  localparam logic [7:0] KEY_P2_B1     = 8'h1B;
  localparam logic [7:0] KEY_P2_B2     = 8'h15;
  localparam logic [7:0] KEY_P2_B3     = 8'h1D;
  localparam logic [7:0] KEY_START0    = 8'h05;
  localparam logic [7:0] KEY_START1    = 8'h06;
  localparam logic [7:0] KEY_COIN0     = 8'h04;
  localparam logic [7:0] KEY_COIN0_ALT = 8'h2E;
  localparam logic [7:0] KEY_COIN1     = 8'h36;
  localparam logic [7:0] KEY_PAUSE     = 8'h0C;
  localparam logic [7:0] KEY_TEST      = 8'h03;

  localparam int CTRL_RIGHT = 0;
  localparam int CTRL_LEFT  = 1;
  localparam int CTRL_DOWN  = 2;
  localparam int CTRL_UP    = 3;
  localparam int CTRL_BTN0  = 4;

  // Directions in [3:0], buttons 0..3 in [7:4]
  typedef logic [7:0] ctrl_t;

  function automatic int joy_start_bit(input int buttons);
    return 4 + buttons;
  endfunction

  function automatic int joy_coin_bit(input int buttons);
    return 5 + buttons;
  endfunction

  function automatic int joy_pause_bit(input int buttons);
    return 6 + buttons;
  endfunction

  function automatic ctrl_t ctrl_mask(input int buttons);
    ctrl_t m;
    m = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      if (k < buttons) m[4+k] = 1'b1;
      else             m[4+k] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/jtframe_coin_pulse.sv
// Stretches a rising edge on trigger into a pulse of exactly COIN_CYCLES clocks;
// edges arriving while a pulse is running are swallowed.
module jtframe_coin_pulse #(
  parameter logic [23:0] COIN_CYCLES = 24'd480000
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse
);

  logic        trig_q;
  logic [23:0] cnt_q, cnt_d;

  // Reload only from idle so a second press cannot extend a running pulse
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 24'd0) begin
      cnt_d = cnt_q - 24'd1;
    end else if (trigger && !trig_q) begin
      cnt_d = COIN_CYCLES;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Edge register and down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      cnt_q  <= 24'd0;
    end else begin
      trig_q <= trigger;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse = (cnt_q != 24'd0);

endmodule

// File: rtl/jtframe_inputs_mapper.sv
// Merges PS/2 key events and per-player MiSTer joystick words into game-polarity
// control buses. Optional autofire on button0 is built when JTFRAME_AUTOFIRE_EN is defined.
module jtframe_inputs_mapper
  import jtframe_inputs_pkg::*;
#(
  parameter int          PLAYERS     = 2,
  parameter int          BUTTONS     = 2,
  parameter logic [23:0] COIN_CYCLES = 24'd480000,
  parameter int          ACTIVE_LOW  = 1
`ifdef JTFRAME_AUTOFIRE_EN
  ,
  parameter logic [23:0] AUTOFIRE_HALF = 24'd1600000
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [10:0]                      ps2_key,
  input  logic [PLAYERS*16-1:0]            joy,
  input  logic                             pause_clr,
`ifdef JTFRAME_AUTOFIRE_EN
  input  logic                             autofire,
`endif
  output logic [PLAYERS*(BUTTONS+4)-1:0]   joystick,
  output logic [PLAYERS-1:0]               start,
  output logic [PLAYERS-1:0]               coin,
  output logic                             test,
  output logic                             pause
);

  localparam int FW = BUTTONS + 4;
  localparam int JW = PLAYERS * FW;
  localparam ctrl_t MASK_P0 = ctrl_mask(BUTTONS);
  localparam ctrl_t MASK_P1 = (PLAYERS > 1) ? ctrl_mask(BUTTONS) : 8'h00;
  localparam logic [1:0] MASK_SYS = (PLAYERS > 1) ? 2'b11 : 2'b01;
  localparam logic [JW-1:0]      INV_J = (ACTIVE_LOW != 0) ? {JW{1'b1}} : {JW{1'b0}};
  localparam logic [PLAYERS-1:0] INV_P = (ACTIVE_LOW != 0) ? {PLAYERS{1'b1}} : {PLAYERS{1'b0}};
  localparam logic               INV_T = (ACTIVE_LOW != 0);

  logic              strobe_q;
  logic              ps2_evt_s;
  ctrl_t [1:0]       key_ctrl_q, key_ctrl_d;
  logic  [1:0]       key_start_q, key_start_d;
  logic  [1:0]       key_coin_q, key_coin_d;
  logic              key_pause_q, key_pause_d;
  logic              key_test_q, key_test_d;

  logic [JW-1:0]      joystick_s, joystick_q;
  logic [PLAYERS-1:0] raw_start_s, raw_coin_s, joy_pause_s, coin_pulse_s;
  logic [PLAYERS-1:0] start_q, coin_q;
  logic               test_q;
  logic               pause_req_s, pause_req_q, pause_q;
  logic               af_gate_s;
  logic               unused_s;

  assign ps2_evt_s = strobe_q ^ ps2_key[10];

  // Scancode decode: an event overwrites the selected latch with the make/break bit
  always_comb begin
    key_ctrl_d  = key_ctrl_q;
    key_start_d = key_start_q;
    key_coin_d  = key_coin_q;
    key_pause_d = key_pause_q;
    key_test_d  = key_test_q;
    if (ps2_evt_s) begin
      case (ps2_key[7:0])
        KEY_RIGHT:                key_ctrl_d[0][CTRL_RIGHT]  = ps2_key[9];
        KEY_LEFT:                 key_ctrl_d[0][CTRL_LEFT]   = ps2_key[9];
        KEY_DOWN:                 key_ctrl_d[0][CTRL_DOWN]   = ps2_key[9];
        KEY_UP:                   key_ctrl_d[0][CTRL_UP]     = ps2_key[9];
        KEY_B0, KEY_B0_ALT:       key_ctrl_d[0][CTRL_BTN0]   = ps2_key[9];
        KEY_B1:                   key_ctrl_d[0][CTRL_BTN0+1] = ps2_key[9];
        KEY_B2:                   key_ctrl_d[0][CTRL_BTN0+2] = ps2_key[9];
        KEY_B3:                   key_ctrl_d[0][CTRL_BTN0+3] = ps2_key[9];
        KEY_P2_RIGHT:             key_ctrl_d[1][CTRL_RIGHT]  = ps2_key[9];
        KEY_P2_LEFT:              key_ctrl_d[1][CTRL_LEFT]   = ps2_key[9];
        KEY_P2_DOWN:              key_ctrl_d[1][CTRL_DOWN]   = ps2_key[9];
        KEY_P2_UP:                key_ctrl_d[1][CTRL_UP]     = ps2_key[9];
        KEY_P2_B0:                key_ctrl_d[1][CTRL_BTN0]   = ps2_key[9];
        KEY_P2_B1:                key_ctrl_d[1][CTRL_BTN0+1] = ps2_key[9];
        KEY_P2_B2:                key_ctrl_d[1][CTRL_BTN0+2] = ps2_key[9];
        KEY_P2_B3:                key_ctrl_d[1][CTRL_BTN0+3] = ps2_key[9];
        KEY_START0:               key_start_d[0] = ps2_key[9];
        KEY_START1:               key_start_d[1] = ps2_key[9];
        KEY_COIN0, KEY_COIN0_ALT: key_coin_d[0]  = ps2_key[9];
        KEY_COIN1:                key_coin_d[1]  = ps2_key[9];
        KEY_PAUSE:                key_pause_d    = ps2_key[9];
        KEY_TEST:                 key_test_d     = ps2_key[9];
        default:                  key_ctrl_d     = key_ctrl_q;
      endcase
    end else begin
      key_ctrl_d = key_ctrl_q;
    end
  end

  // Strobe edge register and key latches; masks keep absent players/buttons clear
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q    <= ps2_key[10];
      key_ctrl_q  <= '0;
      key_start_q <= 2'b00;
      key_coin_q  <= 2'b00;
      key_pause_q <= 1'b0;
      key_test_q  <= 1'b0;
    end else begin
      strobe_q      <= ps2_key[10];
      key_ctrl_q[0] <= key_ctrl_d[0] & MASK_P0;
      key_ctrl_q[1] <= key_ctrl_d[1] & MASK_P1;
      key_start_q   <= key_start_d & MASK_SYS;
      key_coin_q    <= key_coin_d & MASK_SYS;
      key_pause_q   <= key_pause_d;
      key_test_q    <= key_test_d;
    end
  end

`ifdef JTFRAME_AUTOFIRE_EN
  logic [23:0] af_cnt_q;
  logic        af_phase_q;

  // Free-running autofire phase, flipping every AUTOFIRE_HALF clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt_q   <= 24'd0;
      af_phase_q <= 1'b1;
    end else if (af_cnt_q == AUTOFIRE_HALF - 24'd1) begin
      af_cnt_q   <= 24'd0;
      af_phase_q <= ~af_phase_q;
    end else begin
      af_cnt_q   <= af_cnt_q + 24'd1;
      af_phase_q <= af_phase_q;
    end
  end

  assign af_gate_s = autofire ? af_phase_q : 1'b1;
`else
  assign af_gate_s = 1'b1;
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [FW-1:0] raw_s, fire_s;
    logic          key_start_s, key_coin_s;

    // Keyboard only reaches the first two players
    if (p < 2) begin : g_key
      assign raw_s       = joy[16*p +: FW] | key_ctrl_q[p][FW-1:0];
      assign key_start_s = key_start_q[p];
      assign key_coin_s  = key_coin_q[p];
    end else begin : g_nokey
      assign raw_s       = joy[16*p +: FW];
      assign key_start_s = 1'b0;
      assign key_coin_s  = 1'b0;
    end

    // Autofire gate applies to button0 only
    always_comb begin
      fire_s            = raw_s;
      fire_s[CTRL_BTN0] = raw_s[CTRL_BTN0] & af_gate_s;
    end

    assign joystick_s[p*FW +: FW] = fire_s;
    assign raw_start_s[p] = joy[16*p + joy_start_bit(BUTTONS)] | key_start_s;
    assign raw_coin_s[p]  = joy[16*p + joy_coin_bit(BUTTONS)]  | key_coin_s;
    assign joy_pause_s[p] = joy[16*p + joy_pause_bit(BUTTONS)];

    jtframe_coin_pulse #(
      .COIN_CYCLES (COIN_CYCLES)
    ) u_coin (
      .clk     (clk),
      .rst     (rst),
      .trigger (raw_coin_s[p]),
      .pulse   (coin_pulse_s[p])
    );
  end

  assign pause_req_s = key_pause_q | (|joy_pause_s);

  // Game-facing output registers with polarity applied here
  always_ff @(posedge clk) begin
    if (rst) begin
      joystick_q <= INV_J;
      start_q    <= INV_P;
      coin_q     <= INV_P;
      test_q     <= INV_T;
    end else begin
      joystick_q <= joystick_s ^ INV_J;
      start_q    <= raw_start_s ^ INV_P;
      coin_q     <= coin_pulse_s ^ INV_P;
      test_q     <= key_test_q ^ INV_T;
    end
  end

  // Pause toggles on a request edge; the clear has priority over a same-cycle edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_req_q <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      pause_req_q <= pause_req_s;
      if (pause_clr) begin
        pause_q <= 1'b0;
      end else if (pause_req_s && !pause_req_q) begin
        pause_q <= ~pause_q;
      end else begin
        pause_q <= pause_q;
      end
    end
  end

  assign joystick = joystick_q;
  assign start    = start_q;
  assign coin     = coin_q;
  assign test     = test_q;
  assign pause    = pause_q;

  assign unused_s = ^{joy, ps2_key[8], key_ctrl_q, key_start_q, key_coin_q};

endmodule

// File: tb/tb_jtframe_inputs_mapper.sv
// Directed + randomized bench for jtframe_inputs_mapper (PLAYERS=2, BUTTONS=2,
// COIN_CYCLES=16, active-low); autofire steps are built with JTFRAME_AUTOFIRE_EN.
module tb_jtframe_inputs_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic        pause_clr;
  logic [11:0] joystick;
  logic [1:0]  start, coin;
  logic        test, pause;
`ifdef JTFRAME_AUTOFIRE_EN
  logic        autofire;
`endif

  int total = 0;
  int bad   = 0;

  // Key table: scancode -> logical target (p*8+ctrl, 16/17 start, 18/19 coin, 20 pause, 21 test)
  localparam logic [7:0] CODES [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12,
                                        8'h1A, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15,
                                        8'h1D, 8'h05, 8'h06, 8'h04, 8'h2E, 8'h36, 8'h0C, 8'h03};
  localparam int         TGTS  [24] = '{3, 2, 1, 0, 4, 4, 5, 6,
                                        7, 11, 10, 9, 8, 12, 13, 14,
                                        15, 16, 17, 18, 18, 19, 20, 21};
  localparam logic [7:0] UNKNOWN [4] = '{8'h00, 8'hFF, 8'h76, 8'h5A};

  bit   [21:0] lat_now = '0;
  bit   [21:0] lat_lag = '0;
  logic [11:0] exp_j;
  logic [1:0]  exp_st;
  logic        exp_tst;

  always #5 clk = ~clk;

  jtframe_inputs_mapper #(
    .PLAYERS     (2),
    .BUTTONS     (2),
    .COIN_CYCLES (24'd16),
    .ACTIVE_LOW  (1)
`ifdef JTFRAME_AUTOFIRE_EN
    , .AUTOFIRE_HALF (24'd4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_key   (ps2_key),
    .joy       (joy),
    .pause_clr (pause_clr),
`ifdef JTFRAME_AUTOFIRE_EN
    .autofire  (autofire),
`endif
    .joystick  (joystick),
    .start     (start),
    .coin      (coin),
    .test      (test),
    .pause     (pause)
  );

  function automatic logic [11:0] model_js(input bit [21:0] lat, input logic [31:0] j);
    logic [11:0] r;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 6; i++)
        r[p*6+i] = ~(lat[p*8+i] | j[16*p+i]);
    return r;
  endfunction

  function automatic logic [1:0] model_start(input bit [21:0] lat, input logic [31:0] j);
    logic [1:0] r;
    for (int p = 0; p < 2; p++) r[p] = ~(lat[16+p] | j[16*p+6]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expectation is formed from inputs present before the edge; key events lag one extra edge
  task automatic tick();
    exp_j   = model_js(lat_lag, joy);
    exp_st  = model_start(lat_lag, joy);
    exp_tst = ~lat_lag[21];
    @(posedge clk);
    lat_lag = lat_now;
    #1;
  endtask

  task automatic ps2_event(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'($urandom), code};
    for (int i = 0; i < 24; i++)
      if (CODES[i] == code) lat_now[TGTS[i]] = pressed;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_js"}, 32'(joystick), 32'(exp_j));
    check({tag, "_start"}, 32'(start), 32'(exp_st));
    check({tag, "_test"}, 32'(test), 32'(exp_tst));
  endtask

  initial begin
    int lows0, lows1, falls0, idx, runlen, trans;
    logic prev, lastb;

    rst = 1'b1; ps2_key = 11'd0; joy = 32'd0; pause_clr = 1'b0;
`ifdef JTFRAME_AUTOFIRE_EN
    autofire = 1'b0;
`endif
    tick(); tick();
    ps2_key[10] = 1'b1;          // strobe moves during reset: must be absorbed
    tick();
    check("rst_joystick", 32'(joystick), 32'hFFF);
    check("rst_start", 32'(start), 32'h3);
    check("rst_coin", 32'(coin), 32'h3);
    check("rst_test", 32'(test), 32'h1);
    check("rst_pause", 32'(pause), 32'h0);
    rst = 1'b0;
    tick(); tick();
    check("post_rst_no_event", 32'(joystick), 32'hFFF);

    // Right key make/break latency
    ps2_event(8'h74, 1'b1);
    tick(); check("right_make_1clk", 32'(joystick[0]), 32'h1); check_model("right_make1");
    tick(); check("right_make_2clk", 32'(joystick[0]), 32'h0); check_model("right_make2");
    ps2_event(8'h74, 1'b0);
    tick(); check("right_brk_1clk", 32'(joystick[0]), 32'h0);
    tick(); check("right_brk_2clk", 32'(joystick[0]), 32'h1);

    // Player 1 button1 from its own joystick only
    joy = 32'h0020_0000;
    tick();
    check("p1_b1_joy", 32'(joystick[11]), 32'h0);
    check("p0_untouched", 32'(joystick[5:0]), 32'h3F);
    check_model("p1_b1");
    joy = 32'd0;
    tick();

    // Random keys and joystick words (coin/pause bits excluded)
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          ps2_event(UNKNOWN[$urandom_range(0, 3)], 1'($urandom));
        end else begin
          do idx = $urandom_range(0, 23); while (TGTS[idx] >= 18 && TGTS[idx] <= 20);
          ps2_event(CODES[idx], 1'($urandom));
        end
      end
      if ($urandom_range(0, 3) == 0) joy = $urandom & 32'hFE7F_FE7F;
      tick();
      check_model("rand");
    end
    joy = 32'd0;
    for (int i = 0; i < 20; i++) tick();

    // Coin stretch: held 100 cycles, with a re-press 3 cycles in
    lows0 = 0; lows1 = 0; falls0 = 0; prev = 1'b1;
    for (int c = 0; c < 100; c++) begin
      joy[7] = (c == 3) ? 1'b0 : 1'b1;
      tick();
      if (!coin[0]) lows0++;
      if (prev && !coin[0]) falls0++;
      if (!coin[1]) lows1++;
      prev = coin[0];
    end
    check("coin0_width", 32'(lows0), 32'd16);
    check("coin0_single", 32'(falls0), 32'd1);
    check("coin1_quiet", 32'(lows1), 32'd0);
    joy[7] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    lows0 = 0;
    joy[7] = 1'b1;
    for (int i = 0; i < 30; i++) begin tick(); if (!coin[0]) lows0++; end
    check("coin0_repress", 32'(lows0), 32'd16);
    joy[7] = 1'b0;
    tick();

    // Coin from keyboard (alternate coin0 code, then coin1)
    lows0 = 0;
    ps2_event(8'h2E, 1'b1);
    for (int i = 0; i < 30; i++) begin tick(); if (!coin[0]) lows0++; end
    check("coin0_key", 32'(lows0), 32'd16);
    ps2_event(8'h2E, 1'b0); tick();
    lows1 = 0;
    ps2_event(8'h36, 1'b1);
    for (int i = 0; i < 30; i++) begin tick(); if (!coin[1]) lows1++; end
    check("coin1_key", 32'(lows1), 32'd16);
    ps2_event(8'h36, 1'b0); tick(); tick();

    // Pause toggling and clear priority
    check("pause_idle", 32'(pause), 32'h0);
    joy[8] = 1'b1;  tick(); check("pause_on", 32'(pause), 32'h1);
    joy[8] = 1'b0;  tick(); check("pause_hold", 32'(pause), 32'h1);
    joy[24] = 1'b1; tick(); check("pause_off_p1", 32'(pause), 32'h0);
    joy[24] = 1'b0; tick();
    joy[8] = 1'b1; pause_clr = 1'b1; tick(); check("pause_clr_wins", 32'(pause), 32'h0);
    joy[8] = 1'b0; pause_clr = 1'b0; tick(); check("pause_clr_after", 32'(pause), 32'h0);
    ps2_event(8'h0C, 1'b1);
    tick(); check("pause_key_1clk", 32'(pause), 32'h0);
    tick(); check("pause_key_2clk", 32'(pause), 32'h1);
    ps2_event(8'h0C, 1'b0); tick(); tick();
    check("pause_key_rel", 32'(pause), 32'h1);
    pause_clr = 1'b1; tick(); check("pause_clr", 32'(pause), 32'h0);
    pause_clr = 1'b0; tick();

`ifdef JTFRAME_AUTOFIRE_EN
    // Autofire: button0 output toggles in runs of 4 cycles while held
    autofire = 1'b1; joy[4] = 1'b1;
    tick();
    lastb = joystick[4]; runlen = 1; trans = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (joystick[4] !== lastb) begin
        if (trans > 0) check("af_run_len", 32'(runlen), 32'd4);
        trans++; runlen = 1; lastb = joystick[4];
      end else begin
        runlen++;
      end
    end
    check("af_transitions", 32'(trans >= 7), 32'd1);
    autofire = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin tick(); check("af_off_b0", 32'(joystick[4]), 32'h0); end
    joy[4] = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
